clock_gate_ctrl: RTL and testbench
==================================

Name: clock_gate_ctrl

Overview:
- Sequences the enable (`stop`) input of the clock_stop gating cell on behalf of several requesters.
- Wakes the gated clock on demand and holds off grants until the clock has settled.
- Keeps the clock running through a programmable idle window, then shuts it down.
- Sits between the requesting blocks and the gating cell, and is the sole driver of the gate enable.

Parameters:
- NREQ, 4, number of requesters (1..16).
- WAKE_CYCLES, 2, cycles gate_en is high before grants are issued (>=1).
- IDLE_CYCLES, 8, cycles with no demand before the gate is switched off (>=1).
- CNT_W, 8, width of the internal wake/idle counter; must hold max(WAKE_CYCLES, IDLE_CYCLES).

Ports:
- clk  input  1  free-running source clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester level request for the gated clock.
- force_on  input  1  config override: keeps the gate on; counts as demand; never acknowledged.
- gate_en  output  1  enable to the clock gate's stop input; registered.
- ack  output  NREQ  per-requester grant: the gated clock is stable and running; registered.
- gate_on  output  1  status, high in WAKE, ON and IDLE.
- state  output  2  FSM encoding: OFF=0, WAKE=1, ON=2, IDLE=3.
- on_cycles  output  16  count of cycles with gate_en high; saturating.

Behaviour:
- Reset: asynchronous on rst_n low. state=OFF, gate_en=0, ack=0, gate_on=0, internal counter=0, on_cycles=0. gate_en drops immediately, including mid-WAKE or mid-ON. Release is synchronous to the next clk edge.
- demand = |req | force_on, sampled at posedge clk.
- OFF:
  - demand=1 -> WAKE, gate_en<=1, cnt<=0.
  - Otherwise stay in OFF with gate_en=0.
- WAKE:
  - gate_en=1, ack=0.
  - cnt increments each cycle; when cnt==WAKE_CYCLES-1 -> ON.
  - No abort: if demand drops during WAKE, the FSM still completes to ON, then follows ON rules.
- ON:
  - gate_en=1.
  - ack[i]<=req[i] each cycle, so a new requester is granted 1 cycle after raising req.
  - demand=0 -> IDLE, cnt<=0. ack falls on the same edge because req is low.
  - force_on alone keeps ON with ack=0.
- IDLE:
  - gate_en=1, ack=0.
  - demand=1 -> ON; ack follows 1 cycle later, with no re-wake.
  - Else if cnt==IDLE_CYCLES-1 -> OFF, gate_en<=0.
  - Else cnt++.
  - Demand arriving on the same edge as expiry wins: go to ON, gate stays on.
- Latency from OFF:
  - req sampled high at edge t0 -> gate_en high after t0.
  - ON after edge t0+WAKE_CYCLES.
  - ack high after edge t0+WAKE_CYCLES+1 (3 edges for default WAKE_CYCLES=2).
- Shutdown latency: demand sampled low at edge t1 (in ON) -> IDLE; gate_en low after edge t1+IDLE_CYCLES.
- ack[i] is never high unless state==ON at the preceding edge and req[i] was high. ack never asserts while gate_en=0.
- gate_en is a flop output with no combinational path from req. This guarantees glitch-free enable to the gate cell.
- on_cycles increments on every edge where gate_en=1 and saturates at 16'hFFFF. Cleared only by reset.
- The cnt width must hold the parameter values; a mis-sized CNT_W is an elaboration error.

Test Plan:
- Reset then idle: rst_n low 3 cycles, req=0 for 20 cycles -> state=OFF, gate_en=0, ack=0, on_cycles=0 throughout.
- Wake, grant, shutdown: req=4'b0001 held 10 cycles, WAKE=2, IDLE=8 -> gate_en rises after edge 0, ack[0] after edge 3, ack[0] falls on the edge req is sampled low, gate_en falls exactly 8 edges later, on_cycles=gate-high cycle count.
- Idle rescue: drop req, re-raise req[2] at idle cnt=5 -> state IDLE->ON with no WAKE, ack[2] 1 cycle later, gate_en never drops.
- Boundary race: req[1] asserted on the same edge as idle expiry (cnt==7) -> transition to ON, gate_en stays 1; separately, req pulsed 1 cycle during WAKE -> FSM reaches ON, ack stays 0, then IDLE and OFF after 8.
- force_on: force_on=1 with req=0 for 50 cycles -> gate_en=1 from edge 1, state=ON, ack=0; after force_on=0 -> OFF after 8 edges.
- Async reset mid-ON: rst_n low between clock edges while ack=4'b0011 -> gate_en, ack, on_cycles go to 0 immediately with no clock edge; after release, state=OFF until demand.

Source files
------------

// File: rtl/clock_gate_ctrl.sv
// Clock-gate enable sequencer: wakes the gated clock on demand from any requester,
// grants once the clock has settled, and shuts the gate after a programmable idle window.
module clock_gate_ctrl #(
  parameter int NREQ        = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            force_on,
  output logic            gate_en,
  output logic [NREQ-1:0] ack,
  output logic            gate_on,
  output logic [1:0]      state,
  output logic [15:0]     on_cycles
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  localparam int MAX_CYC = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;

  // Elaboration-time parameter sanity: a bad configuration must not build.
  if (NREQ < 1 || NREQ > 16) begin : g_bad_nreq
    $error("clock_gate_ctrl: NREQ must be in 1..16");
  end
  if (WAKE_CYCLES < 1 || IDLE_CYCLES < 1) begin : g_bad_cycles
    $error("clock_gate_ctrl: WAKE_CYCLES and IDLE_CYCLES must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w_range
    $error("clock_gate_ctrl: CNT_W must be in 1..31");
  end else if (64'(MAX_CYC) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cnt_w
    $error("clock_gate_ctrl: CNT_W too narrow for WAKE_CYCLES/IDLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  state_e            state_q;
  logic              gate_en_q;
  logic [NREQ-1:0]   ack_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       on_cycles_q, on_cycles_d;
  logic              demand;

  assign demand = (|req) | force_on;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others regardless of statement order.
  // The asynchronous reset drops gate_en immediately, even mid-WAKE or mid-ON.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      gate_en_q <= 1'b0;
      ack_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          ack_q <= '0;
          if (demand) begin
            state_q   <= ST_WAKE;
            gate_en_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            gate_en_q <= 1'b0;
          end
        end

        // WAKE never aborts: the clock must settle before anything else happens.
        ST_WAKE: begin
          gate_en_q <= 1'b1;
          ack_q     <= '0;
          if (cnt_q == WAKE_LAST) begin
            state_q <= ST_ON;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_ON: begin
          gate_en_q <= 1'b1;
          ack_q     <= req;
          if (!demand) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end

        // Demand seen on the expiry edge wins, keeping the gate on.
        ST_IDLE: begin
          ack_q <= '0;
          if (demand) begin
            state_q   <= ST_ON;
            gate_en_q <= 1'b1;
          end else if (cnt_q == IDLE_LAST) begin
            state_q   <= ST_OFF;
            gate_en_q <= 1'b0;
          end else begin
            gate_en_q <= 1'b1;
            cnt_q     <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q   <= ST_OFF;
          gate_en_q <= 1'b0;
          ack_q     <= '0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  always_comb begin
    on_cycles_d = on_cycles_q;
    if (gate_en_q && (on_cycles_q != 16'hFFFF)) begin
      on_cycles_d = on_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_cycles_q <= '0;
    end else begin
      on_cycles_q <= on_cycles_d;
    end
  end

  assign gate_en   = gate_en_q;
  assign ack       = ack_q;
  assign state     = state_q;
  assign gate_on   = (state_q != ST_OFF);
  assign on_cycles = on_cycles_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl: a countdown-style reference model checked
// on every falling edge, plus literal expectations at the key latency points.
module tb_clock_gate_ctrl;

  localparam int NREQ = 4;
  localparam int WAKE = 2;
  localparam int IDLE = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic            force_on = 1'b0;
  logic            gate_en;
  logic [NREQ-1:0] ack;
  logic            gate_on;
  logic [1:0]      state;
  logic [15:0]     on_cycles;

  int checks = 0;
  int failures = 0;

  clock_gate_ctrl #(
    .NREQ(NREQ), .WAKE_CYCLES(WAKE), .IDLE_CYCLES(IDLE), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .force_on(force_on),
    .gate_en(gate_en), .ack(ack), .gate_on(gate_on), .state(state),
    .on_cycles(on_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: phase plus "edges remaining" countdowns.
  int            m_phase = 0;   // 0 off, 1 wake, 2 on, 3 idle
  int            m_left  = 0;
  bit            m_gate  = 1'b0;
  bit [NREQ-1:0] m_ack   = '0;
  int            m_on    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_gate = 1'b0; m_ack = '0; m_on = 0;
    end else begin
      bit dem;
      dem = (req != '0) || force_on;
      if (m_gate && m_on < 65535) m_on = m_on + 1;
      m_ack = (m_phase == 2) ? req : '0;
      case (m_phase)
        0: if (dem) begin m_phase = 1; m_left = WAKE; m_gate = 1'b1; end
        1: begin m_left = m_left - 1; if (m_left == 0) m_phase = 2; end
        2: if (!dem) begin m_phase = 3; m_left = IDLE; end
        default: begin
          if (dem) m_phase = 2;
          else begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_phase = 0; m_gate = 1'b0; end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("cmp_gate_en",   32'(gate_en),   32'(m_gate));
    check("cmp_ack",       32'(ack),       32'(m_ack));
    check("cmp_state",     32'(state),     32'(m_phase));
    check("cmp_gate_on",   32'(gate_on),   32'(m_phase != 0));
    check("cmp_on_cycles", 32'(on_cycles), 32'(m_on));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset then idle
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("idle_state", 32'(state), 32'd0);
    check("idle_gate", 32'(gate_en), 32'd0);
    check("idle_on_cycles", 32'(on_cycles), 32'd0);

    // Wake, grant, shutdown
    req = 4'b0001;
    tick(1);
    check("wake_gate_rise", 32'(gate_en), 32'd1);
    check("wake_state", 32'(state), 32'd1);
    tick(2);
    check("wake_on_state", 32'(state), 32'd2);
    check("wake_no_ack_yet", 32'(ack), 32'd0);
    tick(1);
    check("wake_ack_rise", 32'(ack), 32'b0001);
    tick(6);
    req = '0;
    tick(1);
    check("shut_ack_fall", 32'(ack), 32'd0);
    check("shut_idle", 32'(state), 32'd3);
    tick(7);
    check("shut_gate_hold", 32'(gate_en), 32'd1);
    tick(1);
    check("shut_gate_fall", 32'(gate_en), 32'd0);
    check("shut_state_off", 32'(state), 32'd0);
    check("shut_on_cycles", 32'(on_cycles), 32'd18);

    // Idle rescue at idle count 5
    req = 4'b0001;
    tick(4);
    req = '0;
    tick(6);
    req = 4'b0100;
    tick(1);
    check("rescue_state_on", 32'(state), 32'd2);
    check("rescue_gate", 32'(gate_en), 32'd1);
    tick(1);
    check("rescue_ack", 32'(ack), 32'b0100);
    req = '0;
    tick(9);
    check("rescue_off", 32'(state), 32'd0);

    // Demand on the idle-expiry edge
    req = 4'b0001;
    tick(4);
    req = '0;
    tick(8);
    req = 4'b0010;
    tick(1);
    check("race_state_on", 32'(state), 32'd2);
    check("race_gate", 32'(gate_en), 32'd1);
    tick(1);
    check("race_ack", 32'(ack), 32'b0010);
    req = '0;
    tick(9);
    check("race_off", 32'(state), 32'd0);

    // One-cycle pulse during WAKE still completes to ON, no grant
    req = 4'b0001;
    tick(1);
    req = '0;
    tick(2);
    check("pulse_on", 32'(state), 32'd2);
    check("pulse_ack", 32'(ack), 32'd0);
    tick(1);
    check("pulse_idle", 32'(state), 32'd3);
    tick(8);
    check("pulse_off", 32'(state), 32'd0);

    // force_on holds the gate on without acknowledgement
    force_on = 1'b1;
    tick(1);
    check("force_gate", 32'(gate_en), 32'd1);
    tick(49);
    check("force_state_on", 32'(state), 32'd2);
    check("force_ack", 32'(ack), 32'd0);
    force_on = 1'b0;
    tick(8);
    check("force_gate_hold", 32'(gate_en), 32'd1);
    tick(1);
    check("force_off", 32'(state), 32'd0);

    // Asynchronous reset between edges while granted
    req = 4'b0011;
    tick(4);
    check("arst_pre_ack", 32'(ack), 32'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gate", 32'(gate_en), 32'd0);
    check("arst_ack", 32'(ack), 32'd0);
    check("arst_on_cycles", 32'(on_cycles), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    req = '0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("arst_stays_off", 32'(state), 32'd0);
    req = 4'b1000;
    tick(4);
    check("arst_rewake_ack", 32'(ack), 32'b1000);
    req = '0;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
